// File: rtl/bc_seq_if.sv
// Host-load, RAM and count-report signals of the box-count sequencer.
interface bc_seq_if #(
  parameter int unsigned MAX_BOX  = 3,
  parameter int unsigned DATA_LEN = 8
);
  localparam int unsigned AddrW = 2 * MAX_BOX + 1;
  localparam int unsigned LvlW  = ($clog2(MAX_BOX + 1) < 2) ? 2 : $clog2(MAX_BOX + 1);

  logic                  start;
  logic                  load_en;
  logic [2*MAX_BOX-1:0]  load_addr;
  logic [DATA_LEN-1:0]   load_data;
  logic                  ram_ren;
  logic [AddrW-1:0]      ram_raddr;
  logic [DATA_LEN-1:0]   ram_rdata;
  logic                  ram_wen;
  logic [AddrW-1:0]      ram_waddr;
  logic [DATA_LEN-1:0]   ram_wdata;
  logic                  busy;
  logic                  done;
  logic                  cnt_valid;
  logic [LvlW-1:0]       cnt_level;
  logic [AddrW-1:0]      cnt_value;

  // Host and RAM side
  modport master (
    output start, load_en, load_addr, load_data, ram_rdata,
    input  ram_ren, ram_raddr, ram_wen, ram_waddr, ram_wdata,
    input  busy, done, cnt_valid, cnt_level, cnt_value
  );

  // Sequencer side
  modport slave (
    input  start, load_en, load_addr, load_data, ram_rdata,
    output ram_ren, ram_raddr, ram_wen, ram_waddr, ram_wdata,
    output busy, done, cnt_valid, cnt_level, cnt_value
  );
endinterface

// File: rtl/bc_seq.sv
// Box-count sequencer: repeatedly reduces a 2^MAX_BOX square image by summing 2x2 blocks
// (ping-ponging between two RAM banks) and reports the number of nonzero boxes per level.
module bc_seq #(
  parameter int unsigned MAX_BOX  = 3,
  parameter int unsigned DATA_LEN = 8
) (
  input logic     CLK,
  input logic     RST_N,
  bc_seq_if.slave bus
);
  localparam int unsigned AddrW = 2 * MAX_BOX + 1;
  localparam int unsigned LvlW  = ($clog2(MAX_BOX + 1) < 2) ? 2 : $clog2(MAX_BOX + 1);
  localparam int unsigned AccW  = DATA_LEN + 2;

  localparam logic [AddrW-1:0] CntMax  = {1'b1, {(2 * MAX_BOX){1'b0}}};
  localparam logic [LvlW-1:0]  OneLvl  = LvlW'(1);
  localparam logic [LvlW-1:0]  LastLvl = LvlW'(MAX_BOX);
  localparam logic [AccW-1:0]  DataMax = AccW'({DATA_LEN{1'b1}});

  typedef enum logic [2:0] {StIdle, StRpt0, StRd, StWr, StRpt, StDone} state_e;

  state_e               state_q, state_d;
  logic [1:0]           sub_q, sub_d;
  logic [LvlW-1:0]      lvl_q, lvl_d;
  logic [MAX_BOX-1:0]   row_q, row_d;
  logic [MAX_BOX-1:0]   col_q, col_d;
  logic [AccW-1:0]      acc_q, acc_d;
  logic [AddrW-1:0]     cnt_q, cnt_d;
  logic                 ren_q, ren_d;
  logic [AddrW-1:0]     raddr_q, raddr_d;
  logic                 wen_q, wen_d;
  logic [AddrW-1:0]     waddr_q, waddr_d;
  logic [DATA_LEN-1:0]  wdata_q, wdata_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 cnt_valid_q, cnt_valid_d;
  logic [LvlW-1:0]      cnt_level_q, cnt_level_d;
  logic [AddrW-1:0]     cnt_value_q, cnt_value_d;

  logic [AccW-1:0]      sum_w;
  logic [DATA_LEN-1:0]  sum_sat;
  logic [MAX_BOX-1:0]   side_last;

  // Address of quadrant 'sub' of output cell (r,c) in the source bank.
  function automatic logic [AddrW-1:0] rd_addr(input logic bank, input logic [MAX_BOX-1:0] r,
                                               input logic [MAX_BOX-1:0] c,
                                               input logic [1:0] sub);
    logic [MAX_BOX-1:0] rr;
    logic [MAX_BOX-1:0] cc;
    rr = (r << 1) | MAX_BOX'(sub[1]);
    cc = (c << 1) | MAX_BOX'(sub[0]);
    return {bank, rr, cc};
  endfunction

  // Highest cell index along one side at level lvl.
  function automatic logic [MAX_BOX-1:0] side_m1(input logic [LvlW-1:0] lvl);
    return MAX_BOX'((1 << (MAX_BOX - int'(lvl))) - 1);
  endfunction

  function automatic logic [AddrW-1:0] inc_sat(input logic [AddrW-1:0] cnt);
    return (cnt == CntMax) ? cnt : cnt + AddrW'(1);
  endfunction

  // Block sum: the fourth operand only arrives in the write cycle, so the write data is
  // formed here rather than in a register.
  always_comb begin
    sum_w     = acc_q + AccW'(bus.ram_rdata);
    sum_sat   = (sum_w > DataMax) ? {DATA_LEN{1'b1}} : sum_w[DATA_LEN-1:0];
    side_last = side_m1(lvl_q);
  end

  // Next-state logic; outputs are registered from the values of the state being entered.
  always_comb begin
    state_d     = state_q;
    sub_d       = sub_q;
    lvl_d       = lvl_q;
    row_d       = row_q;
    col_d       = col_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ren_d       = 1'b0;
    raddr_d     = '0;
    wen_d       = 1'b0;
    waddr_d     = '0;
    wdata_d     = '0;
    cnt_valid_d = 1'b0;
    cnt_level_d = '0;
    cnt_value_d = '0;

    case (state_q)
      StIdle: begin
        if (bus.load_en) begin
          wen_d   = 1'b1;
          waddr_d = {1'b0, bus.load_addr};
          wdata_d = bus.load_data;
          if (bus.load_data != '0) cnt_d = inc_sat(cnt_q);
        end
        if (bus.start) begin
          state_d     = StRpt0;
          cnt_valid_d = 1'b1;
          cnt_value_d = cnt_d;
        end
      end
      StRpt0: begin
        cnt_d   = '0;
        lvl_d   = OneLvl;
        row_d   = '0;
        col_d   = '0;
        sub_d   = 2'd0;
        state_d = StRd;
        ren_d   = 1'b1;
        raddr_d = rd_addr(1'b0, '0, '0, 2'd0);
      end
      StRd: begin
        // Data for the read issued in sub-cycle k is on ram_rdata in sub-cycle k+1.
        acc_d = (sub_q == 2'd0) ? '0 : sum_w;
        if (sub_q == 2'd3) begin
          state_d = StWr;
          wen_d   = 1'b1;
          waddr_d = {lvl_q[0], row_q, col_q};
        end else begin
          sub_d   = sub_q + 2'd1;
          ren_d   = 1'b1;
          raddr_d = rd_addr(~lvl_q[0], row_q, col_q, sub_q + 2'd1);
        end
      end
      StWr: begin
        if (sum_sat != '0) cnt_d = inc_sat(cnt_q);
        sub_d = 2'd0;
        if (row_q == side_last && col_q == side_last) begin
          state_d     = StRpt;
          cnt_valid_d = 1'b1;
          cnt_level_d = lvl_q;
          cnt_value_d = cnt_d;
        end else begin
          if (col_q == side_last) begin
            col_d = '0;
            row_d = row_q + MAX_BOX'(1);
          end else begin
            col_d = col_q + MAX_BOX'(1);
          end
          state_d = StRd;
          ren_d   = 1'b1;
          raddr_d = rd_addr(~lvl_q[0], row_d, col_d, 2'd0);
        end
      end
      StRpt: begin
        cnt_d = '0;
        if (lvl_q == LastLvl) begin
          state_d = StDone;
        end else begin
          lvl_d   = lvl_q + OneLvl;
          row_d   = '0;
          col_d   = '0;
          state_d = StRd;
          ren_d   = 1'b1;
          raddr_d = rd_addr(~lvl_d[0], '0, '0, 2'd0);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      sub_q       <= '0;
      lvl_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ren_q       <= 1'b0;
      raddr_q     <= '0;
      wen_q       <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cnt_valid_q <= 1'b0;
      cnt_level_q <= '0;
      cnt_value_q <= '0;
    end else begin
      state_q     <= state_d;
      sub_q       <= sub_d;
      lvl_q       <= lvl_d;
      row_q       <= row_d;
      col_q       <= col_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ren_q       <= ren_d;
      raddr_q     <= raddr_d;
      wen_q       <= wen_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cnt_valid_q <= cnt_valid_d;
      cnt_level_q <= cnt_level_d;
      cnt_value_q <= cnt_value_d;
    end
  end

  assign bus.ram_ren   = ren_q;
  assign bus.ram_raddr = raddr_q;
  assign bus.ram_wen   = wen_q;
  assign bus.ram_waddr = waddr_q;
  assign bus.ram_wdata = (state_q == StWr) ? sum_sat : wdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cnt_valid = cnt_valid_q;
  assign bus.cnt_level = cnt_level_q;
  assign bus.cnt_value = cnt_value_q;

endmodule

// File: tb/tb_bc_seq.sv
// Bench for bc_seq: behavioural RAM, event monitor and an image-level reference model.
module tb_bc_seq;
  localparam int MB   = 3;
  localparam int DL   = 8;
  localparam int SIDE = 1 << MB;
  localparam int NPIX = SIDE * SIDE;
  localparam int DMAX = (1 << DL) - 1;

  typedef struct {int a; int b; int c;} ev_t;

  logic CLK   = 1'b0;
  logic RST_N = 1'b1;

  bc_seq_if #(.MAX_BOX(MB), .DATA_LEN(DL)) bus ();

  bc_seq #(.MAX_BOX(MB), .DATA_LEN(DL)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int vectors     = 0;
  int miscompares = 0;

  // Two-bank RAM, read data valid the cycle after ram_ren.
  logic [DL-1:0] mem [0:2*NPIX-1];
  always @(posedge CLK) begin
    if (bus.ram_wen) mem[bus.ram_waddr] <= bus.ram_wdata;
    if (bus.ram_ren) bus.ram_rdata <= mem[bus.ram_raddr];
  end

  int pcount = 0;
  always @(posedge CLK) pcount <= pcount + 1;

  // Monitor: cycle numbers are relative to the cycle in which start is presented.
  int  t0 = 0;
  bit  logging = 1'b0;
  ev_t got_rpt[$];
  ev_t got_wr[$];
  int  got_done[$];
  int  busy_cnt, ren_cnt, overlaps;
  always @(negedge CLK) begin
    if (logging) begin
      if (bus.cnt_valid)
        got_rpt.push_back('{a: int'(bus.cnt_level), b: int'(bus.cnt_value), c: pcount - t0});
      if (bus.ram_wen)
        got_wr.push_back('{a: int'(bus.ram_waddr), b: int'(bus.ram_wdata), c: pcount - t0});
      if (bus.done) got_done.push_back(pcount - t0);
      if (bus.busy) busy_cnt <= busy_cnt + 1;
      if (bus.ram_ren) ren_cnt <= ren_cnt + 1;
      if (bus.ram_ren && bus.ram_wen) overlaps <= overlaps + 1;
    end
  end

  // Reference model state
  int  img[NPIX];
  int  img_next[NPIX];
  int  nz_loads;
  ev_t exp_rpt[$];
  ev_t exp_wr[$];
  int  exp_done;
  int  exp_ren;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},   64'(bus.busy),      64'd0);
    check({tag, "_done"},   64'(bus.done),      64'd0);
    check({tag, "_cval"},   64'(bus.cnt_valid), 64'd0);
    check({tag, "_clvl"},   64'(bus.cnt_level), 64'd0);
    check({tag, "_cvalue"}, 64'(bus.cnt_value), 64'd0);
    check({tag, "_ren"},    64'(bus.ram_ren),   64'd0);
    check({tag, "_raddr"},  64'(bus.ram_raddr), 64'd0);
    check({tag, "_wen"},    64'(bus.ram_wen),   64'd0);
    check({tag, "_waddr"},  64'(bus.ram_waddr), 64'd0);
    check({tag, "_wdata"},  64'(bus.ram_wdata), 64'd0);
  endtask

  // Host writes every pixel 'times' times; loads return one cycle after the last write.
  task automatic load_img(input int times);
    for (int k = 0; k < times; k++) begin
      for (int i = 0; i < NPIX; i++) begin
        bus.load_en   = 1'b1;
        bus.load_addr = (2*MB)'(i);
        bus.load_data = DL'(img[i]);
        if (img[i] != 0) nz_loads++;
        @(posedge CLK);
        #1;
      end
    end
    bus.load_en = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic rand_img();
    for (int i = 0; i < NPIX; i++)
      img[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, DMAX));
  endtask

  // Box sums per level, expected reports, writes and cycle numbers.
  task automatic build_model();
    int lv[0:MB][0:SIDE-1][0:SIDE-1];
    int st, side, s, nz, rp;
    exp_rpt.delete();
    exp_wr.delete();
    exp_ren = 0;
    for (int r = 0; r < SIDE; r++)
      for (int c = 0; c < SIDE; c++) lv[0][r][c] = img[r*SIDE+c];
    exp_rpt.push_back('{a: 0, b: (nz_loads > NPIX) ? NPIX : nz_loads, c: 1});
    img_next = img;
    st = 2;
    for (int l = 1; l <= MB; l++) begin
      side = SIDE >> l;
      nz = 0;
      for (int r = 0; r < side; r++) begin
        for (int c = 0; c < side; c++) begin
          s = lv[l-1][2*r][2*c] + lv[l-1][2*r][2*c+1] + lv[l-1][2*r+1][2*c]
            + lv[l-1][2*r+1][2*c+1];
          if (s > DMAX) s = DMAX;
          lv[l][r][c] = s;
          if (s != 0) nz++;
          exp_wr.push_back('{a: ((l % 2) << (2*MB)) | (r << MB) | c, b: s,
                             c: st + 5*(r*side + c) + 4});
          if (l % 2 == 0) img_next[r*SIDE+c] = s;
          exp_ren += 4;
        end
      end
      rp = st + 5*side*side;
      exp_rpt.push_back('{a: l, b: nz, c: rp});
      st = rp + 1;
    end
    exp_done = st;
  endtask

  // Runs one sequence; optionally pulses start/load_en or asserts reset at a given cycle.
  task automatic run_seq(input string name, input int disturb_at, input int reset_at);
    got_rpt.delete();
    got_wr.delete();
    got_done.delete();
    busy_cnt = 0;
    ren_cnt  = 0;
    overlaps = 0;
    build_model();
    nz_loads  = 0;
    bus.start = 1'b1;
    t0        = pcount;
    logging   = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge CLK);
      #1;
      bus.start   = 1'b0;
      bus.load_en = 1'b0;
      if (pcount - t0 == disturb_at) begin
        bus.start     = 1'b1;
        bus.load_en   = 1'b1;
        bus.load_addr = (2*MB)'(9);
        bus.load_data = DL'(8'hA5);
      end
      if (pcount - t0 == reset_at) begin
        #2 RST_N = 1'b0;
        #1 check_zero({name, "_rst"});
        #3 RST_N = 1'b1;
        logging = 1'b0;
        return;
      end
      if (got_done.size() > 0) break;
    end
    repeat (2) begin
      @(posedge CLK);
      #1;
    end
    logging = 1'b0;

    check({name, "_ndone"}, 64'(got_done.size()), 64'd1);
    if (got_done.size() > 0) check({name, "_done_cyc"}, 64'(got_done[0]), 64'(exp_done));
    check({name, "_nrpt"}, 64'(got_rpt.size()), 64'(exp_rpt.size()));
    for (int i = 0; i < got_rpt.size() && i < exp_rpt.size(); i++) begin
      check($sformatf("%s_rpt%0d_lvl", name, i), 64'(got_rpt[i].a), 64'(exp_rpt[i].a));
      check($sformatf("%s_rpt%0d_cnt", name, i), 64'(got_rpt[i].b), 64'(exp_rpt[i].b));
      check($sformatf("%s_rpt%0d_cyc", name, i), 64'(got_rpt[i].c), 64'(exp_rpt[i].c));
    end
    check({name, "_nwr"}, 64'(got_wr.size()), 64'(exp_wr.size()));
    for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++) begin
      check($sformatf("%s_wr%0d_addr", name, i), 64'(got_wr[i].a), 64'(exp_wr[i].a));
      check($sformatf("%s_wr%0d_data", name, i), 64'(got_wr[i].b), 64'(exp_wr[i].b));
      check($sformatf("%s_wr%0d_cyc", name, i), 64'(got_wr[i].c), 64'(exp_wr[i].c));
    end
    check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_done));
    check({name, "_reads"}, 64'(ren_cnt), 64'(exp_ren));
    check({name, "_ren_wen_overlap"}, 64'(overlaps), 64'd0);
    img = img_next;
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.load_en   = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    nz_loads      = 0;

    #2 RST_N = 1'b0;
    #10 check_zero("reset");
    @(posedge CLK);
    #3 RST_N = 1'b1;
    @(posedge CLK);
    #1;

    // All ones
    for (int i = 0; i < NPIX; i++) img[i] = 1;
    load_img(1);
    run_seq("ones", -1, -1);

    // Single pixel (5,6) = 7
    for (int i = 0; i < NPIX; i++) img[i] = 0;
    img[5*SIDE+6] = 7;
    load_img(1);
    run_seq("single", -1, -1);

    // All 200, loaded twice: box sums and level-0 count both saturate
    for (int i = 0; i < NPIX; i++) img[i] = 200;
    load_img(2);
    run_seq("sat200", -1, -1);

    // All zero
    for (int i = 0; i < NPIX; i++) img[i] = 0;
    load_img(1);
    run_seq("zeros", -1, -1);

    // Random images
    for (int t = 0; t < 3; t++) begin
      rand_img();
      load_img(1);
      run_seq($sformatf("rand%0d", t), -1, -1);
    end

    // start/load_en while busy, then a rerun with no new loads
    rand_img();
    load_img(1);
    run_seq("busy_ignore", 90, -1);
    run_seq("rerun", -1, -1);

    // Reset mid level 2, reload on the first edge after release, rerun
    rand_img();
    load_img(1);
    run_seq("midrst", -1, 95);
    rand_img();
    img[0] = 3;
    nz_loads = 0;
    load_img(1);
    run_seq("after_rst", -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bc_seq.md
BC_SEQ -- requirements
Module: bc_seq

Interface
REQ-001 SHALL have parameter MAX_BOX, default 3: image side = 2^MAX_BOX pixels; number of reduction levels = MAX_BOX.
REQ-002 SHALL have parameter DATA_LEN, default 8: pixel and box-sum width.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port RST_N, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: begin box-count sequence; honoured only in IDLE.
REQ-006 SHALL have port load_en, input, 1 bit: host pixel write strobe; honoured only in IDLE.
REQ-007 SHALL have ports load_addr (input, 2*MAX_BOX bits, {row,col}) and load_data (input, DATA_LEN bits): host pixel write.
REQ-008 SHALL have ports ram_ren (output, 1), ram_raddr (output, 2*MAX_BOX+1) and ram_rdata (input, DATA_LEN): RAM read; data valid exactly 1 cycle after ram_ren.
REQ-009 SHALL have ports ram_wen (output, 1), ram_waddr (output, 2*MAX_BOX+1) and ram_wdata (output, DATA_LEN): RAM write.
REQ-010 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-011 SHALL have port done, output, 1 bit: single-cycle pulse at end of sequence.
REQ-012 SHALL have ports cnt_valid (output, 1), cnt_level (output, 2 bits min, wide enough for MAX_BOX) and cnt_value (output, 2*MAX_BOX+1): per-level nonzero-box count report.

Function
REQ-013 SHALL use RAM address format {bank, row[MAX_BOX-1:0], col[MAX_BOX-1:0]}; level L reads bank (L-1)&1 and writes bank L&1; host loads go to bank 0.
REQ-014 SHALL implement FSM states IDLE, RPT0, RD (4 sub-cycles), WR, RPT, DONE.
REQ-015 In IDLE, load_en SHALL produce ram_wen=1 on the next cycle with ram_waddr={0,load_addr} and ram_wdata=load_data.
REQ-016 In IDLE, each accepted load with load_data!=0 SHALL increment the level-0 counter (saturating at 4^MAX_BOX); rewrites of the same address are not deduplicated.
REQ-017 start in IDLE SHALL move the FSM to RPT0, which lasts 1 cycle and drives cnt_valid=1, cnt_level=0, cnt_value=level-0 count; the level-0 counter then clears.
REQ-018 For each level L=1..MAX_BOX and each output cell (r,c), r,c < 2^(MAX_BOX-L), row-major, the FSM SHALL issue 4 consecutive reads (2r,2c), (2r,2c+1), (2r+1,2c), (2r+1,2c+1) followed by 1 WR cycle, i.e. 5 cycles per cell.
REQ-019 Each WR SHALL write {L&1, r, c} with the sum of the 4 returned values, saturated to 2^DATA_LEN-1.
REQ-020 Each WR with a nonzero sum SHALL increment the level counter.
REQ-021 After the last cell of a level, a 1-cycle RPT SHALL drive cnt_valid=1 with cnt_level=L and cnt_value=count, then clear the counter and go to the next level, or to DONE if L==MAX_BOX.
REQ-022 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-023 start and load_en while busy SHALL be ignored with no side effects.
REQ-024 ram_ren and ram_wen SHALL never both be high in the same cycle.
REQ-025 All outputs SHALL be registered.
REQ-026 Sequence length SHALL be 1 + sum over L of (5*4^(MAX_BOX-L) + 1) + 1 cycles from start to done.

Reset
REQ-027 RST_N low SHALL immediately force IDLE and drive all outputs and counters to 0, including mid-sequence; RAM contents are not restored.
REQ-028 After RST_N releases, the block SHALL accept load_en and start on the first rising edge.

Verification (MAX_BOX=3, DATA_LEN=8, start sampled at cycle 0)
REQ-029 All 64 pixels loaded =1, then start -> counts (0:64, 1:16, 2:4, 3:1); level-1/2/3 writes = 4/16/64; RPT0 at cycle 1; level RPTs at cycles 82, 103, 109; done at cycle 110.
REQ-030 Only pixel (5,6)=7 -> counts 1,1,1,1; level-1 write addr {1,2,3} data 7; level-3 write addr {1,0,0} data 7.
REQ-031 All pixels =200 -> every level-1/2/3 write data 255 (saturated); counts 64,16,4,1.
REQ-032 All pixels zero -> all counts 0, all writes data 0, done at cycle 110.
REQ-033 start and load_en pulsed during level 2 -> no ram_wen to bank 0 from host, sequence timing unchanged, single done pulse.
REQ-034 RST_N low during level 2 -> busy=0, all outputs 0 on assertion; a new start then runs to done with correct counts.
